gf_bch_enc_engine: RTL
======================

// Module: gf_bch_enc_engine
//
// PURPOSE
// Multibit systematic BCH encoder. It takes pDAT_W bits per cycle, LSB first.
// It forwards the message words unchanged, then appends the parity words, which are the
// remainder of m(x)*x^pPAR_W mod g(x). It is the transmit-side counterpart of the
// syndrome / Berlekamp / Chien decoder chain and produces words in the order that chain consumes.
//
// PARAMETERS
// pDAT_W    4      bits per input/output word; bit 0 is earliest in time
// pK        4      message bits per frame; must be a multiple of pDAT_W (shortened codes allowed)
// pPAR_W    8      parity bits = deg g(x); must be a multiple of pDAT_W
// pGEN_POLY 9'h1D1 generator g(x), bit i = coeff x^i, width pPAR_W+1, bit pPAR_W must be 1
//
// PORTS
// iclk     in   1       clock
// ireset   in   1       synchronous reset, active high
// iclkena  in   1       clock enable; low freezes all state and outputs
// isop     in   1       first message word of frame (qualified by ival)
// ival     in   1       input word valid
// ieop     in   1       last message word of frame (qualified by ival)
// idat     in   pDAT_W  message word, LSB first (bit 0 = highest remaining message degree)
// ordy     out  1       encoder accepts input this cycle
// osop     out  1       first codeword word
// oval     out  1       output word valid
// oeop     out  1       last codeword word (last parity word)
// odat     out  pDAT_W  codeword word, LSB first
//
// BEHAVIOUR
// - Reset: ordy=1, osop=0, oval=0, oeop=0, odat=0, LFSR=0, state=DATA, word counter=0.
// - All outputs are registered. Latency is 1 cycle from the accepted input word to the same word on odat.
// - An input word is accepted when ival & ordy & iclkena.
// - State DATA:
//   - An accepted word with isop=1 clears the LFSR before it is absorbed, so the word is
//     absorbed into a zero remainder, and resets the word counter.
//   - An accepted word with isop=0 while no frame is open is dropped: no output, LFSR unchanged.
//   - Each accepted word is absorbed into the LFSR in pDAT_W serial steps, done combinationally
//     in one cycle, bit 0 first.
//     One step: fb = bit ^ r[pPAR_W-1]; r = {r[pPAR_W-2:0],1'b0} ^ (fb ? pGEN_POLY[pPAR_W-1:0] : 0).
//   - Each accepted word is echoed: odat=idat, oval=1, osop=isop.
//   - The word counter counts to pK/pDAT_W.
//   - The end of the message is reached when ieop=1 or when the counter hits pK/pDAT_W,
//     whichever comes first. ieop is authoritative. At that point go to FLUSH and drop ordy to 0
//     in the same cycle's registered output.
// - State FLUSH:
//   - Lasts pPAR_W/pDAT_W cycles; ival is ignored and ordy=0.
//   - Each cycle emits the pDAT_W highest LFSR bits, with r[pPAR_W-1] in odat[0]
//     (highest degree first), then shifts the LFSR left by pDAT_W with zero fill.
//   - The last parity word has oeop=1. The next cycle returns to DATA with ordy=1 and the LFSR=0.
// - Back-to-back frames: isop may be accepted on the first cycle after the last parity word.
//   There is no gap.
// - An isop inside an open DATA frame aborts it and restarts: the LFSR is cleared and the
//   counter reset. No parity is emitted for the aborted frame.
// - ireset in any state, including mid-FLUSH, returns to the reset values on the next edge.
//   Partial parity is discarded.
// - With iclkena=0, all registers hold and oval keeps its value. Downstream qualifies oval with iclkena.
// - The data path has no width growth; all arithmetic is GF(2) XOR.
//
// TESTING
// Default parameters are a shortened BCH(15,7) with k=4 and W=4: 1 data word, 2 parity words.
// 1. After reset, frame idat=4'h0 -> odat 0x0, 0x0, 0x0; osop on word 1; oeop on word 3; ordy low 2 cycles.
// 2. Frame idat=4'h8 (message x^0 only) -> odat 0x8, 0xB, 0x8. The parity is 0xD1.
// 3. Linearity: frames A=4'h3, B=4'h5 and A^B=4'h6 -> the parity of A^B equals the XOR of the parities of A and B.
// 4. Back-to-back: the next isop is presented as the last parity word leaves -> no bubble; the second codeword is correct.
// 5. Abort and reset: with pK=8 the frame is 2 words. A new isop on word 2 gives the parity of the new frame only.
//    Reset asserted during the first parity word gives oval=0 and ordy=1 next cycle.
// 6. Sweep: with pDAT_W=1 and pK=7 (full BCH(15,7)), random messages -> every codeword
//    is divisible by g(x), checked with a reference polynomial model.

Source files
------------

// File: rtl/gf_bch_enc_engine.sv
// gf_bch_enc_engine: systematic multibit BCH encoder, echoes message words then appends parity words
module gf_bch_enc_engine #(
    parameter int                pDAT_W    = 4,
    parameter int                pK        = 4,
    parameter int                pPAR_W    = 8,
    parameter logic [pPAR_W:0]   pGEN_POLY = 9'h1D1
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              iclkena,
    input  logic              isop,
    input  logic              ival,
    input  logic              ieop,
    input  logic [pDAT_W-1:0] idat,
    output logic              ordy,
    output logic              osop,
    output logic              oval,
    output logic              oeop,
    output logic [pDAT_W-1:0] odat
);
    localparam int NW = pK / pDAT_W;
    localparam int NP = pPAR_W / pDAT_W;
    localparam int CW = $clog2((NW > NP ? NW : NP) + 1);

    typedef enum logic {DATA, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [pPAR_W-1:0]   lfsr_q, lfsr_d, r;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_n;
    logic                open_q, open_d;
    logic                ordy_q, ordy_d, osop_q, osop_d, oval_q, oval_d, oeop_q, oeop_d;
    logic [pDAT_W-1:0]   odat_q, odat_d;

    assign ordy = ordy_q;
    assign osop = osop_q;
    assign oval = oval_q;
    assign oeop = oeop_q;
    assign odat = odat_q;

    // next state: absorb and echo message words in DATA, shift parity out highest degree first in FLUSH
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        open_d  = open_q;
        ordy_d  = ordy_q;
        osop_d  = 1'b0;
        oval_d  = 1'b0;
        oeop_d  = 1'b0;
        odat_d  = odat_q;
        r       = '0;
        cnt_n   = '0;
        if (state_q == DATA) begin
            r = isop ? '0 : lfsr_q;
            for (int i = 0; i < pDAT_W; i++)
                r = (r << 1) ^ ((idat[i] ^ r[pPAR_W-1]) ? pGEN_POLY[pPAR_W-1:0] : '0);
            cnt_n = (isop ? '0 : cnt_q) + 1'b1;
            if (ival && ordy_q && (isop || open_q)) begin
                lfsr_d = r;
                oval_d = 1'b1;
                osop_d = isop;
                odat_d = idat;
                if (ieop || cnt_n == CW'(NW)) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                    ordy_d  = 1'b0;
                    open_d  = 1'b0;
                end else begin
                    cnt_d  = cnt_n;
                    open_d = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < pDAT_W; i++)
                odat_d[i] = lfsr_q[pPAR_W-1-i];
            lfsr_d = lfsr_q << pDAT_W;
            oval_d = 1'b1;
            oeop_d = (cnt_q == CW'(NP - 1));
            cnt_d  = cnt_q + 1'b1;
            if (oeop_d) begin
                state_d = DATA;
                cnt_d   = '0;
                ordy_d  = 1'b1;
                lfsr_d  = '0;
            end
        end
    end

    // state and registered outputs, frozen while the clock enable is low
    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_q <= DATA;
            lfsr_q  <= '0;
            cnt_q   <= '0;
            open_q  <= 1'b0;
            ordy_q  <= 1'b1;
            osop_q  <= 1'b0;
            oval_q  <= 1'b0;
            oeop_q  <= 1'b0;
            odat_q  <= '0;
        end else if (iclkena) begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            open_q  <= open_d;
            ordy_q  <= ordy_d;
            osop_q  <= osop_d;
            oval_q  <= oval_d;
            oeop_q  <= oeop_d;
            odat_q  <= odat_d;
        end
    end
endmodule
